// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the sequential MUL AB / DIV AB controller:
// SFR addresses, op codes and FSM states.
package muldiv_seq_pkg;

   localparam logic [7:0] SFR_ACC = 8'hE0;
   localparam logic [7:0] SFR_B   = 8'hF0;

   localparam logic MD_MUL = 1'b0;
   localparam logic MD_DIV = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_WR_ACC,
      ST_WR_B,
      ST_DONE
   } md_state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Decoder-side handshake plus SFR write port and PSW flag outputs of muldiv_seq.
interface muldiv_seq_if;
   logic       start;
   logic       op;
   logic [7:0] acc_in;
   logic [7:0] b_in;
   logic       busy;
   logic       done;
   logic       sfr_wr_en;
   logic       sfr_wr_bit_en;
   logic [7:0] sfr_addr;
   logic [7:0] sfr_data;
   logic       flag_wr;
   logic       ov_out;
   logic       cy_out;

   modport slave (
      input  start, op, acc_in, b_in,
      output busy, done, sfr_wr_en, sfr_wr_bit_en, sfr_addr, sfr_data,
             flag_wr, ov_out, cy_out
   );

   modport master (
      output start, op, acc_in, b_in,
      input  busy, done, sfr_wr_en, sfr_wr_bit_en, sfr_addr, sfr_data,
             flag_wr, ov_out, cy_out
   );
endinterface

// File: rtl/muldiv_dp.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per step.
module muldiv_dp
   import muldiv_seq_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic       step,
   input  logic       op_div,
   input  logic [2:0] cnt,
   input  logic [7:0] a_in,
   input  logic [7:0] b_in,
   output logic [7:0] result_lo,
   output logic [7:0] result_hi,
   output logic       div0
);

   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic [15:0] prod_q;
   logic [8:0]  rem_q;

   logic [8:0]  rem_sh;
   logic        rem_ge;
   logic [8:0]  rem_nx;
   logic [15:0] addend;

   // For DIV the dividend register shifts left and collects quotient bits in its LSB.
   always_comb begin
      rem_sh = {rem_q[7:0], a_q[7]};
      rem_ge = (rem_sh >= {1'b0, b_q});
      rem_nx = rem_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
      addend = a_q[cnt] ? ({8'h00, b_q} << cnt) : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         prod_q <= '0;
         rem_q  <= '0;
      end else if (load) begin
         a_q    <= a_in;
         b_q    <= b_in;
         prod_q <= '0;
         rem_q  <= '0;
      end else if (step) begin
         if (op_div == MD_DIV) begin
            a_q   <= {a_q[6:0], rem_ge};
            rem_q <= rem_nx;
         end else begin
            prod_q <= prod_q + addend;
         end
      end
   end

   always_comb begin
      result_lo = (op_div == MD_DIV) ? a_q        : prod_q[7:0];
      result_hi = (op_div == MD_DIV) ? rem_q[7:0] : prod_q[15:8];
      div0      = (op_div == MD_DIV) && (b_q == '0);
   end

endmodule

// File: rtl/muldiv_seq.sv
// MUL AB / DIV AB sequencer: 8 compute cycles, ACC then B SFR writes, then a
// done/flag_wr pulse carrying OV.
module muldiv_seq
   import muldiv_seq_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   muldiv_seq_if.slave bus
);

   md_state_t  state_q, state_d;
   logic [2:0] cnt_q;
   logic       op_q;
   logic       ov_q;

   logic       load;
   logic       step;
   logic [7:0] result_lo;
   logic [7:0] result_hi;
   logic       div0;

   muldiv_dp u_dp (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .step      (step),
      .op_div    (op_q),
      .cnt       (cnt_q),
      .a_in      (bus.acc_in),
      .b_in      (bus.b_in),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .div0      (div0)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_MUL;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            op_q  <= bus.op;
            cnt_q <= '0;
         end else if (step) begin
            cnt_q <= cnt_q + 3'd1;
         end
         // Captured on leaving WR_B so it is valid during DONE and held afterwards.
         if (state_q == ST_WR_B)
            ov_q <= (op_q == MD_DIV) ? div0 : (result_hi != '0);
      end
   end

   always_comb begin
      state_d           = state_q;
      load              = 1'b0;
      step              = 1'b0;
      bus.busy          = (state_q != ST_IDLE);
      bus.done          = 1'b0;
      bus.flag_wr       = 1'b0;
      bus.sfr_wr_en     = 1'b0;
      bus.sfr_wr_bit_en = 1'b0;
      bus.sfr_addr      = '0;
      bus.sfr_data      = '0;
      bus.ov_out        = ov_q;
      bus.cy_out        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            step = 1'b1;
            if (cnt_q == 3'd7)
               state_d = ST_WR_ACC;
         end
         ST_WR_ACC: begin
            bus.sfr_wr_en = !div0;
            bus.sfr_addr  = SFR_ACC;
            bus.sfr_data  = result_lo;
            state_d       = ST_WR_B;
         end
         ST_WR_B: begin
            bus.sfr_wr_en = !div0;
            bus.sfr_addr  = SFR_B;
            bus.sfr_data  = result_hi;
            state_d       = ST_DONE;
         end
         ST_DONE: begin
            bus.done    = 1'b1;
            bus.flag_wr = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
